// File: rtl/video_pipe_sync.sv
// video_pipe_sync: VGA timing, frame-buffer read, CLUT and overlays.
// Console overlay is built only when VIDEO_PIPE_CONSOLE_EN is defined.
module video_pipe_sync #(
  parameter int CCW   = 8,
  parameter int MAW   = 19,
  parameter int MDW   = 8,
  parameter int H_ACT = 640,
  parameter int H_FP  = 16,
  parameter int H_SYN = 96,
  parameter int H_BP  = 48,
  parameter int V_ACT = 480,
  parameter int V_FP  = 10,
  parameter int V_SYN = 2,
  parameter int V_BP  = 33,
  parameter int CON_H = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           en,
  input  logic           border_en,
  input  logic           console_en,
  input  logic           vram_clk_w,
  input  logic           vram_clk_en_w,
  input  logic           vram_we,
  input  logic [MAW-1:0] vram_adr_w,
  input  logic [MDW-1:0] vram_dat_w,
  output logic           vid_active,
  output logic           vid_hsync,
  output logic           vid_vsync,
  output logic [CCW-1:0] vid_r,
  output logic [CCW-1:0] vid_g,
  output logic [CCW-1:0] vid_b
);

  localparam logic [11:0] HA  = 12'(H_ACT);
  localparam logic [11:0] HL  = 12'(H_ACT - 1);
  localparam logic [11:0] HSS = 12'(H_ACT + H_FP);
  localparam logic [11:0] HSE = 12'(H_ACT + H_FP + H_SYN);
  localparam logic [11:0] HT  = 12'(H_ACT + H_FP + H_SYN + H_BP - 1);
  localparam logic [11:0] VA  = 12'(V_ACT);
  localparam logic [11:0] VL  = 12'(V_ACT - 1);
  localparam logic [11:0] VSS = 12'(V_ACT + V_FP);
  localparam logic [11:0] VSE = 12'(V_ACT + V_FP + V_SYN);
  localparam logic [11:0] VT  = 12'(V_ACT + V_FP + V_SYN + V_BP - 1);

  logic [11:0]      h_q, h_d, v_q, v_d;
  logic [MAW-1:0]   adr_q, adr_d;
  logic             act_c, hs_c, vs_c;
  logic [MDW-1:0]   idx_q;
  logic [3*CCW-1:0] clut_q;
  logic             act1_q, hs1_q, vs1_q;
  logic             act2_q, hs2_q, vs2_q;
  logic             act3_q, hs3_q, vs3_q;
  logic [11:0]      x1_q, y1_q, x2_q, y2_q;
  logic [3*CCW-1:0] rgb_q, rgb_d;
  logic             brd;

  // Address runs with the raster; reset to 0 as the frame wraps.
  always_comb begin
    act_c = (h_q < HA) && (v_q < VA);
    hs_c  = !((h_q >= HSS) && (h_q < HSE));
    vs_c  = !((v_q >= VSS) && (v_q < VSE));
    h_d   = h_q + 12'd1;
    v_d   = v_q;
    adr_d = act_c ? adr_q + MAW'(1) : adr_q;
    if (h_q == HT) begin
      h_d = '0;
      v_d = v_q + 12'd1;
      if (v_q == VT) begin
        v_d   = '0;
        adr_d = '0;
      end
    end
  end

  if (1) begin : g_ram
    logic [MDW-1:0] mem [0:(1<<MAW)-1];
    always_ff @(posedge vram_clk_w)
      if (vram_clk_en_w && vram_we)
        mem[vram_adr_w] <= vram_dat_w;
    always_ff @(posedge clk)
      if (clk_en) idx_q <= mem[adr_q];
  end

  if (1) begin : g_clut
    logic [3*CCW-1:0] mem [0:(1<<MDW)-1];
    for (genvar i = 0; i < (1<<MDW); i++) begin : g_ent
      localparam logic [CCW+MDW-1:0] T =
        {MDW'(i), CCW'(0)};
      assign mem[i] = {3{T[CCW+MDW-1 -: CCW]}};
    end
    always_ff @(posedge clk)
      if (clk_en) clut_q <= mem[idx_q];
  end

  assign brd = border_en &&
    (x2_q == '0 || x2_q == HL || y2_q == '0 || y2_q == VL);

`ifdef VIDEO_PIPE_CONSOLE_EN
  localparam logic [11:0] VC = 12'(V_ACT - CON_H);
  logic           con;
  logic [CCW-1:0] cr, cg, cb;
  assign {cr, cg, cb} = clut_q;
  assign con = console_en && (y2_q >= VC);
`else
  localparam int unused_con_h = CON_H;
  logic unused_console;
  assign unused_console = console_en;
`endif

  always_comb begin
    rgb_d = clut_q;
    if (!act2_q) rgb_d = '0;
    else if (brd) rgb_d = '1;
`ifdef VIDEO_PIPE_CONSOLE_EN
    else if (con) rgb_d = {cr >> 1, cg >> 1, cb >> 1};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || (clk_en && !en)) begin
      h_q    <= '0;
      v_q    <= '0;
      adr_q  <= '0;
      act1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      x1_q   <= '0;
      y1_q   <= '0;
      act2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      x2_q   <= '0;
      y2_q   <= '0;
      act3_q <= 1'b0;
      hs3_q  <= 1'b1;
      vs3_q  <= 1'b1;
      rgb_q  <= '0;
    end else if (clk_en) begin
      h_q    <= h_d;
      v_q    <= v_d;
      adr_q  <= adr_d;
      act1_q <= act_c;
      hs1_q  <= hs_c;
      vs1_q  <= vs_c;
      x1_q   <= h_q;
      y1_q   <= v_q;
      act2_q <= act1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      x2_q   <= x1_q;
      y2_q   <= y1_q;
      act3_q <= act2_q;
      hs3_q  <= hs2_q;
      vs3_q  <= vs2_q;
      rgb_q  <= rgb_d;
    end
  end

  assign vid_active = act3_q;
  assign vid_hsync  = hs3_q;
  assign vid_vsync  = vs3_q;
  assign {vid_r, vid_g, vid_b} = rgb_q;

endmodule

// File: tb/tb_video_pipe_sync.sv
// tb_video_pipe_sync: full-size instance for line timing and pixel data,
// reduced-geometry instance for whole-frame, overlay and clk_en checks.
module tb_video_pipe_sync;

  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SCH = 4;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
`ifdef VIDEO_PIPE_CONSOLE_EN
  localparam bit CON_BUILT = 1'b1;
`else
  localparam bit CON_BUILT = 1'b0;
`endif

  logic clk = 1'b0, wclk = 1'b0, rst;
  always #5 clk = ~clk;
  always #7 wclk = ~wclk;

  logic f_en, f_ce, f_act, f_hs, f_vs;
  logic [7:0] f_r, f_g, f_b;
  logic s_en, s_ce, s_bord, s_con, s_act, s_hs, s_vs;
  logic [7:0] s_r, s_g, s_b;
  logic s_wce, s_we;
  logic [18:0] s_wadr;
  logic [7:0] s_wdat;

  logic [7:0] smem [0:255];
  int errs = 0, checks = 0, shown = 0;

  video_pipe_sync uf (
    .clk(clk), .rst(rst), .clk_en(f_ce), .en(f_en),
    .border_en(1'b0), .console_en(1'b0),
    .vram_clk_w(wclk), .vram_clk_en_w(1'b0), .vram_we(1'b0),
    .vram_adr_w(19'd0), .vram_dat_w(8'd0),
    .vid_active(f_act), .vid_hsync(f_hs), .vid_vsync(f_vs),
    .vid_r(f_r), .vid_g(f_g), .vid_b(f_b));

  video_pipe_sync #(
    .H_ACT(SHA), .H_FP(SHF), .H_SYN(SHS), .H_BP(SHB),
    .V_ACT(SVA), .V_FP(SVF), .V_SYN(SVS), .V_BP(SVB),
    .CON_H(SCH)
  ) us (
    .clk(clk), .rst(rst), .clk_en(s_ce), .en(s_en),
    .border_en(s_bord), .console_en(s_con),
    .vram_clk_w(wclk), .vram_clk_en_w(s_wce), .vram_we(s_we),
    .vram_adr_w(s_wadr), .vram_dat_w(s_wdat),
    .vid_active(s_act), .vid_hsync(s_hs), .vid_vsync(s_vs),
    .vid_r(s_r), .vid_g(s_g), .vid_b(s_b));

  // Expected {active,hsync,vsync,r,g,b} for raster position k (k<0: idle).
  function automatic logic [26:0] model(int k, bit full,
                                        bit bord, bit con);
    int ha, hf, hs, hb, va, vf, vs, vb, h, v;
    logic [7:0] c;
    bit act;
    ha = full ? 640 : SHA; hf = full ? 16 : SHF;
    hs = full ? 96 : SHS;  hb = full ? 48 : SHB;
    va = full ? 480 : SVA; vf = full ? 10 : SVF;
    vs = full ? 2 : SVS;   vb = full ? 33 : SVB;
    if (k < 0) return {3'b011, 24'h0};
    h = k % (ha + hf + hs + hb);
    v = (k / (ha + hf + hs + hb)) % (va + vf + vs + vb);
    act = (h < ha) && (v < va);
    c = 8'h00;
    if (act) begin
      c = full ? 8'(v) : smem[v * ha + h];
      if (bord && (h == 0 || h == ha - 1 || v == 0 || v == va - 1))
        c = 8'hFF;
      else if (con && CON_BUILT && v >= va - (full ? 32 : SCH))
        c = c >> 1;
    end
    return {act, !(h >= ha + hf && h < ha + hf + hs),
            !(v >= va + vf && v < va + vf + vs), c, c, c};
  endfunction

  task automatic test_reset();
    logic [26:0] of, os;
    for (int i = 0; i < 13; i++) begin
      if (i == 10) rst = 1'b0;
      @(negedge clk);
      of = {f_act, f_hs, f_vs, f_r, f_g, f_b};
      os = {s_act, s_hs, s_vs, s_r, s_g, s_b};
      checks += 2;
      if (of !== model(-1, 1, 0, 0)) begin
        errs++;
        if (shown < 20) $display("FAIL reset_full got=%h exp=%h",
                                 of, model(-1, 1, 0, 0));
        shown++;
      end
      if (os !== model(-1, 0, 0, 0)) begin
        errs++;
        if (shown < 20) $display("FAIL reset_small got=%h exp=%h",
                                 os, model(-1, 0, 0, 0));
        shown++;
      end
    end
  endtask

  task automatic test_full_rows();
    int n = 0, nh = 0, na = 0, first = -1;
    logic [26:0] e, o;
    f_ce = 1'b1; f_en = 1'b1;
    for (int i = 0; i < 40 * 800 + 2; i++) begin
      n++;
      @(negedge clk);
      e = model(n - 3, 1, 0, 0);
      o = {f_act, f_hs, f_vs, f_r, f_g, f_b};
      checks++;
      if (o !== e) begin
        errs++;
        if (shown < 20) $display("FAIL full_pix k=%0d got=%h exp=%h",
                                 n - 3, o, e);
        shown++;
      end
      nh += int'(!f_hs);
      na += int'(f_act);
      if (f_act && first < 0) first = n;
    end
    f_en = 1'b0;
    checks += 3;
    if (first != 3) begin
      errs++;
      $display("FAIL first_active got=%0d exp=3", first);
    end
    if (nh != 40 * 96) begin
      errs++;
      $display("FAIL hsync_low got=%0d exp=%0d", nh, 40 * 96);
    end
    if (na != 40 * 640) begin
      errs++;
      $display("FAIL full_active got=%0d exp=%0d", na, 40 * 640);
    end
    @(negedge clk);
  endtask

  task automatic test_small_frames();
    int n = 0, na = 0, nh = 0, nv = 0;
    logic [26:0] e, o;
    s_en = 1'b0; s_ce = 1'b1; s_bord = 1'b0; s_con = 1'b0;
    @(negedge clk);
    s_en = 1'b1;
    for (int i = 0; i < 2 * SHT * SVT + 2; i++) begin
      n++;
      @(negedge clk);
      e = model(n - 3, 0, 0, 0);
      o = {s_act, s_hs, s_vs, s_r, s_g, s_b};
      checks++;
      if (o !== e) begin
        errs++;
        if (shown < 20) $display("FAIL frame k=%0d got=%h exp=%h",
                                 n - 3, o, e);
        shown++;
      end
      na += int'(s_act); nh += int'(!s_hs); nv += int'(!s_vs);
    end
    checks += 3;
    if (na != 2 * SHA * SVA) begin
      errs++;
      $display("FAIL frame_active got=%0d exp=%0d", na, 2 * SHA * SVA);
    end
    if (nh != 2 * SVT * SHS) begin
      errs++;
      $display("FAIL frame_hsync got=%0d exp=%0d", nh, 2 * SVT * SHS);
    end
    if (nv != 2 * SVS * SHT) begin
      errs++;
      $display("FAIL frame_vsync got=%0d exp=%0d", nv, 2 * SVS * SHT);
    end
  endtask

  task automatic test_border();
    int n = 0, k;
    logic [26:0] e, o;
    s_en = 1'b0; s_ce = 1'b1; s_bord = 1'b1; s_con = 1'b1;
    @(negedge clk);
    s_en = 1'b1;
    for (int i = 0; i < SHT * SVT + 2; i++) begin
      n++;
      @(negedge clk);
      k = n - 3;
      e = model(k, 0, 1, 1);
      o = {s_act, s_hs, s_vs, s_r, s_g, s_b};
      checks++;
      if (o !== e) begin
        errs++;
        if (shown < 20) $display("FAIL border k=%0d got=%h exp=%h",
                                 k, o, e);
        shown++;
      end
      if (k == 0 || k == 5 * SHT + SHA - 1 || k == (SVA - 1) * SHT + 5) begin
        checks++;
        if ({s_r, s_g, s_b} !== 24'hFFFFFF) begin
          errs++;
          $display("FAIL border_pt k=%0d got=%h exp=ffffff",
                   k, {s_r, s_g, s_b});
        end
      end
      if (k == 5 * SHT + 5) begin
        checks++;
        if ({s_r, s_g, s_b} !== 24'h050505) begin
          errs++;
          $display("FAIL border_in got=%h exp=050505", {s_r, s_g, s_b});
        end
      end
    end
    s_bord = 1'b0; s_con = 1'b0;
  endtask

  task automatic test_console();
    int n = 0, k;
    logic [26:0] e, o;
    logic [7:0] want;
    want = CON_BUILT ? 8'h66 : 8'hCC;
    s_en = 1'b0; s_ce = 1'b1; s_bord = 1'b0; s_con = 1'b1;
    @(negedge clk);
    s_en = 1'b1;
    for (int i = 0; i < SHT * SVT + 2; i++) begin
      n++;
      @(negedge clk);
      k = n - 3;
      e = model(k, 0, 0, 1);
      o = {s_act, s_hs, s_vs, s_r, s_g, s_b};
      checks++;
      if (o !== e) begin
        errs++;
        if (shown < 20) $display("FAIL console k=%0d got=%h exp=%h",
                                 k, o, e);
        shown++;
      end
      if (k == 9 * SHT + 5) begin
        checks++;
        if (s_g !== want) begin
          errs++;
          $display("FAIL console_in got=%h exp=%h", s_g, want);
        end
      end
      if (k == 7 * SHT + 5) begin
        checks++;
        if (s_b !== 8'hBF) begin
          errs++;
          $display("FAIL console_out got=%h exp=bf", s_b);
        end
      end
    end
    s_con = 1'b0;
  endtask

  task automatic test_clk_en_stretch();
    int n = 0, it = 0, na = 0;
    logic [26:0] e, o;
    s_en = 1'b0; s_ce = 1'b1;
    @(negedge clk);
    s_en = 1'b1;
    while (n < SHT * SVT + 2 && it < 20000) begin
      it++;
      s_ce = 1'($urandom_range(0, 1));
      if (s_ce) n++;
      @(negedge clk);
      e = model(n - 3, 0, 0, 0);
      o = {s_act, s_hs, s_vs, s_r, s_g, s_b};
      checks++;
      if (o !== e) begin
        errs++;
        if (shown < 20) $display("FAIL stretch k=%0d got=%h exp=%h",
                                 n - 3, o, e);
        shown++;
      end
      if (s_ce) na += int'(s_act);
    end
    checks += 2;
    if (n < SHT * SVT + 2) begin
      errs++;
      $display("FAIL stretch_timeout got=%0d exp=%0d", n, SHT * SVT + 2);
    end
    if (na != SHA * SVA) begin
      errs++;
      $display("FAIL stretch_active got=%0d exp=%0d", na, SHA * SVA);
    end
  endtask

  task automatic test_restart_write();
    int n = 0, it = 0, a;
    logic [26:0] e, o;
    logic [7:0] d;
    s_en = 1'b0; s_ce = 1'b1;
    @(negedge clk);
    s_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      n++;
      @(negedge clk);
    end
    s_en = 1'b0; s_ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) s_ce = 1'b1;
      @(negedge clk);
      e = (i == 2) ? model(-1, 0, 0, 0) : model(n - 3, 0, 0, 0);
      o = {s_act, s_hs, s_vs, s_r, s_g, s_b};
      checks++;
      if (o !== e) begin
        errs++;
        $display("FAIL en_drop step=%0d got=%h exp=%h", i, o, e);
      end
    end
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(0, SHA * SVA - 1);
      d = 8'($urandom);
      @(negedge wclk);
      s_wadr = 19'(a); s_wdat = d;
      s_wce = (i != 8); s_we = (i != 9);
      @(posedge wclk);
      if (i < 8) smem[a] = d;
    end
    @(negedge wclk);
    s_wce = 1'b0; s_we = 1'b0;
    @(negedge clk);
    n = 0;
    s_en = 1'b1;
    while (n < SHT * SVT + 2 && it < 20000) begin
      it++;
      s_ce = 1'($urandom_range(0, 1));
      if (s_ce) n++;
      @(negedge clk);
      e = model(n - 3, 0, 0, 0);
      o = {s_act, s_hs, s_vs, s_r, s_g, s_b};
      checks++;
      if (o !== e) begin
        errs++;
        if (shown < 20) $display("FAIL rewrite k=%0d got=%h exp=%h",
                                 n - 3, o, e);
        shown++;
      end
    end
    checks++;
    if (n < SHT * SVT + 2) begin
      errs++;
      $display("FAIL rewrite_timeout got=%0d exp=%0d", n, SHT * SVT + 2);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    f_en = 1'b0; f_ce = 1'b1;
    s_en = 1'b0; s_ce = 1'b1; s_bord = 1'b0; s_con = 1'b0;
    s_wce = 1'b0; s_we = 1'b0; s_wadr = '0; s_wdat = '0;
    for (int y = 0; y < 480; y++)
      for (int x = 0; x < 640; x++)
        uf.g_ram.mem[y * 640 + x] = 8'(y);
    for (int i = 0; i < 256; i++) smem[i] = 8'($urandom);
    smem[5 * SHA + 5] = 8'h05;
    smem[9 * SHA + 5] = 8'hCC;
    smem[7 * SHA + 5] = 8'hBF;
    for (int i = 0; i < 256; i++) us.g_ram.mem[i] = smem[i];
    test_reset();
    test_full_rows();
    test_small_frames();
    test_border();
    test_console();
    test_clk_en_stretch();
    test_restart_write();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
